// File: rtl/tt_scan_ctrl.sv
// Scan-chain master: shifts a CHAIN_LEN-bit word into the DPLL scan chain, LSB first, and captures what falls out.
// Latency: CHAIN_LEN shift cycles after acceptance, then a 1-cycle o_done pulse; back-to-back ops are CHAIN_LEN+2 cycles apart.
// Backpressure: i_start is accepted only in IDLE (o_busy=0); starts while busy are dropped, never queued.
//
// Ports:
//   i_clk_gen, i_rst_n          scan clock (shared with the chain flops), async active-low reset
//   i_start, i_shift_data       operation request and word to load (sampled only at acceptance)
//   o_busy, o_done              SHIFT/DONE indicator, 1-cycle capture-valid pulse
//   o_capture_data, o_mismatch  captured word (bit k = scan_out in shift cycle k), loopback-check result
//   o_scan_en, o_scan_in        registered drive of the chain scan port
//   i_scan_out                  chain output
//
// Build option: define TT_SCAN_CTRL_LOOPBACK_CHECK_EN to compare each captured word against the
// word shifted in by the previous operation; otherwise o_mismatch is tied to 0.

module tt_scan_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 i_clk_gen,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [CHAIN_LEN-1:0] i_shift_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_capture_data,
    output logic                 o_mismatch,
    output logic                 o_scan_en,
    output logic                 o_scan_in,
    input  logic                 i_scan_out
);

    localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    // Latched word, rotated right once per shift cycle. Bit 1 is always the next bit to drive,
    // and after CHAIN_LEN rotations it holds the original word again (used by the loopback check).
    logic [CHAIN_LEN-1:0] shift_reg;
    logic                 last_bit;

    assign last_bit = (cnt == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            shift_reg      <= '0;
            o_capture_data <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_scan_en      <= 1'b0;
            o_scan_in      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        shift_reg <= i_shift_data;
                        cnt       <= '0;
                        o_scan_en <= 1'b1;
                        o_scan_in <= i_shift_data[0];
                        o_busy    <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // scan_out is sampled before the chain shifts on this same edge.
                    o_capture_data[cnt[IDX_W-1:0]] <= i_scan_out;
                    shift_reg <= {shift_reg[0], shift_reg[CHAIN_LEN-1:1]};
                    if (last_bit) begin
                        o_scan_en <= 1'b0;
                        o_scan_in <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        o_scan_in <= shift_reg[1];
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    o_scan_en <= 1'b0;
                    o_scan_in <= 1'b0;
                    o_done    <= 1'b0;
                    o_busy    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
    logic [CHAIN_LEN-1:0] prev_word;
    logic                 prev_vld;
    logic [CHAIN_LEN-1:0] capture_nxt;

    // Full captured word as it will look in DONE, so the verdict lines up with o_done.
    always_comb begin
        capture_nxt                     = o_capture_data;
        capture_nxt[cnt[IDX_W-1:0]]     = i_scan_out;
    end

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_word  <= '0;
            prev_vld   <= 1'b0;
            o_mismatch <= 1'b0;
        end else if (state == ST_SHIFT && last_bit) begin
            o_mismatch <= prev_vld && (capture_nxt != prev_word);
        end else if (state == ST_DONE) begin
            // shift_reg has completed a full rotation and equals the word just shifted in.
            prev_word <= shift_reg;
            prev_vld  <= 1'b1;
        end
    end
`else
    assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_tt_scan_ctrl.sv
module tb_tt_scan_ctrl;

    localparam int CL = 8;

    logic          i_clk_gen;
    logic          i_rst_n;
    logic          i_start;
    logic [CL-1:0] i_shift_data;
    logic          o_busy;
    logic          o_done;
    logic [CL-1:0] o_capture_data;
    logic          o_mismatch;
    logic          o_scan_en;
    logic          o_scan_in;
    logic          i_scan_out;

    int errors = 0;
    int checks = 0;

`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
    localparam logic LB_EN = 1'b1;
`else
    localparam logic LB_EN = 1'b0;
`endif

    tt_scan_ctrl #(.CHAIN_LEN(CL)) dut (
        .i_clk_gen      (i_clk_gen),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_shift_data   (i_shift_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_capture_data (o_capture_data),
        .o_mismatch     (o_mismatch),
        .o_scan_en      (o_scan_en),
        .o_scan_in      (o_scan_in),
        .i_scan_out     (i_scan_out)
    );

    initial i_clk_gen = 1'b0;
    always #5 i_clk_gen = ~i_clk_gen;

    // Chain model: 8 scan flops, scan_in enters at bit 7, scan_out is bit 0.
    logic [CL-1:0] chain;
    logic          preload_req;
    logic [CL-1:0] preload_val;
    logic          force_one;

    always @(posedge i_clk_gen) begin
        if (preload_req)
            chain <= preload_val;
        else if (o_scan_en)
            chain <= {o_scan_in, chain[CL-1:1]};
    end

    assign i_scan_out = force_one ? 1'b1 : chain[0];

    task automatic preload(input logic [CL-1:0] v);
        @(negedge i_clk_gen);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge i_clk_gen);
        preload_req = 1'b0;
    endtask

    // Runs one operation over a fixed 16-cycle window and reports what was seen.
    task automatic run_op(input logic [CL-1:0] data, input int pulse_cycle,
                          output logic [CL-1:0] seq, output int en_cycles, output int busy_cycles,
                          output int done_cnt, output logic [CL-1:0] cap, output logic mism);
        seq = '0; en_cycles = 0; busy_cycles = 0; done_cnt = 0; cap = '0; mism = 1'b0;
        @(negedge i_clk_gen);
        i_start      = 1'b1;
        i_shift_data = data;
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk_gen);
            i_start = 1'b0;
            if (i == 0) i_shift_data = ~data;
            if (o_busy) busy_cycles++;
            if (o_done) begin
                done_cnt++;
                cap  = o_capture_data;
                mism = o_mismatch;
            end
            if (o_scan_en) begin
                if (en_cycles < CL) seq[en_cycles] = o_scan_in;
                en_cycles++;
                if (en_cycles - 1 == pulse_cycle) i_start = 1'b1;
            end
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b1; i_shift_data = 8'hFF;
        repeat (3) @(negedge i_clk_gen);
        checks++; if (o_scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en: got %b want 0", o_scan_en); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
        checks++; if (o_scan_in !== 1'b0) begin errors++; $display("FAIL reset_scan_in: got %b want 0", o_scan_in); end
        checks++; if (o_capture_data !== 8'h00) begin errors++; $display("FAIL reset_capture: got %h want 00", o_capture_data); end
        checks++; if (o_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b want 0", o_mismatch); end
        i_start = 1'b0;
        i_rst_n = 1'b1;
        @(negedge i_clk_gen);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy got %b want 0", o_busy); end
    endtask

    task automatic test_basic_shift();
        logic [CL-1:0] seq, cap; int en, bz, dn; logic mm;
        preload(8'h3C);
        run_op(8'hA5, -1, seq, en, bz, dn, cap, mm);
        checks++; if (seq !== 8'hA5) begin errors++; $display("FAIL basic_scan_in_seq: got %b want 10100101", seq); end
        checks++; if (en !== 8) begin errors++; $display("FAIL basic_scan_en_len: got %0d want 8", en); end
        checks++; if (bz !== 9) begin errors++; $display("FAIL basic_busy_len: got %0d want 9", bz); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", dn); end
        checks++; if (cap !== 8'h3C) begin errors++; $display("FAIL basic_capture: got %h want 3c", cap); end
        checks++; if (mm !== 1'b0) begin errors++; $display("FAIL basic_mismatch: got %b want 0", mm); end
        checks++; if (o_capture_data !== 8'h3C) begin errors++; $display("FAIL basic_capture_hold: got %h want 3c", o_capture_data); end
    endtask

    task automatic test_loopback();
        logic [CL-1:0] seq, cap; int en, bz, dn; logic mm;
        run_op(8'h00, -1, seq, en, bz, dn, cap, mm);
        checks++; if (cap !== 8'hA5) begin errors++; $display("FAIL loop_capture: got %h want a5", cap); end
        checks++; if (mm !== 1'b0) begin errors++; $display("FAIL loop_mismatch_clean: got %b want 0", mm); end
        force_one = 1'b1;
        run_op(8'h00, -1, seq, en, bz, dn, cap, mm);
        force_one = 1'b0;
        checks++; if (cap !== 8'hFF) begin errors++; $display("FAIL loop_capture_forced: got %h want ff", cap); end
        checks++; if (mm !== LB_EN) begin errors++; $display("FAIL loop_mismatch_forced: got %b want %b", mm, LB_EN); end
        checks++; if (o_mismatch !== LB_EN) begin errors++; $display("FAIL loop_mismatch_hold: got %b want %b", o_mismatch, LB_EN); end
        // Chain now holds 00 shifted in during the forced run; prev word is 00 -> clean.
        run_op(8'h5A, -1, seq, en, bz, dn, cap, mm);
        checks++; if (cap !== 8'h00) begin errors++; $display("FAIL loop_capture_after: got %h want 00", cap); end
        checks++; if (mm !== 1'b0) begin errors++; $display("FAIL loop_mismatch_cleared: got %b want 0", mm); end
    endtask

    task automatic test_start_while_busy();
        logic [CL-1:0] seq, cap; int en, bz, dn; logic mm;
        run_op(8'h96, 3, seq, en, bz, dn, cap, mm);
        checks++; if (en !== 8) begin errors++; $display("FAIL busy_ign_scan_en_len: got %0d want 8", en); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL busy_ign_done_count: got %0d want 1", dn); end
        checks++; if (seq !== 8'h96) begin errors++; $display("FAIL busy_ign_seq: got %h want 96", seq); end
        checks++; if (cap !== 8'h5A) begin errors++; $display("FAIL busy_ign_capture: got %h want 5a", cap); end
    endtask

    task automatic test_reset_mid_op();
        logic [CL-1:0] seq, cap; int en, bz, dn; logic mm;
        @(negedge i_clk_gen);
        i_start = 1'b1; i_shift_data = 8'h0F;
        @(negedge i_clk_gen);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk_gen);
        checks++; if (o_scan_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_scan_en: got %b want 1", o_scan_en); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_scan_en !== 1'b0) begin errors++; $display("FAIL midrst_scan_en: got %b want 0", o_scan_en); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
        checks++; if (o_capture_data !== 8'h00) begin errors++; $display("FAIL midrst_capture: got %h want 00", o_capture_data); end
        @(negedge i_clk_gen);
        i_rst_n = 1'b1;
        preload(8'hC3);
        run_op(8'h33, -1, seq, en, bz, dn, cap, mm);
        checks++; if (en !== 8) begin errors++; $display("FAIL midrst_rerun_len: got %0d want 8", en); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL midrst_rerun_done: got %0d want 1", dn); end
        checks++; if (cap !== 8'hC3) begin errors++; $display("FAIL midrst_rerun_capture: got %h want c3", cap); end
        checks++; if (seq !== 8'h33) begin errors++; $display("FAIL midrst_rerun_seq: got %h want 33", seq); end
        checks++; if (mm !== 1'b0) begin errors++; $display("FAIL midrst_rerun_mismatch: got %b want 0", mm); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] en_pat, en_exp, dn_pat, dn_exp;
        @(negedge i_clk_gen);
        i_start = 1'b1; i_shift_data = 8'h81;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk_gen);
            en_pat[i] = o_scan_en;
            dn_pat[i] = o_done;
            en_exp[i] = (i % 10) < 8;
            dn_exp[i] = (i % 10) == 8;
        end
        i_start = 1'b0;
        checks++; if (en_pat !== en_exp) begin errors++; $display("FAIL b2b_scan_en_pattern: got %b want %b", en_pat, en_exp); end
        checks++; if (dn_pat !== dn_exp) begin errors++; $display("FAIL b2b_done_pattern: got %b want %b", dn_pat, dn_exp); end
        repeat (12) @(negedge i_clk_gen);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_idle: busy got %b want 0", o_busy); end
        checks++; if (o_capture_data !== 8'h81) begin errors++; $display("FAIL b2b_capture: got %h want 81", o_capture_data); end
    endtask

    initial begin
        preload_req = 1'b0; preload_val = '0; force_one = 1'b0;
        i_rst_n = 1'b0; i_start = 1'b0; i_shift_data = '0;
        test_reset();
        test_basic_shift();
        test_loopback();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
